// File: rtl/keypad_scan_entry.sv
// Multiplexed 4x4 keypad scanner with debounce and decimal number entry.
// Accepted digits accumulate into a 13-bit value; Enter commits it to entered.
module keypad_scan_entry #(
  parameter int unsigned SCAN_DIV_BITS  = 18,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ROW,
  output logic [3:0]  COL,
  output logic [12:0] value,
  output logic [12:0] entered,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        enter,
  output logic        ovf
);
  localparam int unsigned VW = 13;
  localparam int unsigned CW = 4;
  localparam int unsigned NW = 17;

  typedef enum logic [1:0] {SCAN, DEB, HELD, REL} state_t;

  state_t                   state, state_next;
  logic [SCAN_DIV_BITS-1:0] div;
  logic                     tick;
  logic [3:0]               row_meta, srow;
  logic [1:0]               row_sel, row_sel_next;
  logic [CW-1:0]            cnt, cnt_next;
  logic [3:0]               col_next;
  logic                     accept;
  logic [1:0]               col_idx;
  logic [3:0]               code;
  logic [NW-1:0]            digit_sum;
  logic [VW-1:0]            value_next, entered_next;
  logic                     enter_next, ovf_next;

  assign tick = &div;

  always_comb begin
    case (COL)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase
  end

  // Key legend: rows 0..2 carry digits 1..9 plus A/B/C; row 3 is 0 F E D.
  always_comb begin
    case ({row_sel, col_idx})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  default: code = 4'hD;
    endcase
  end

  // Scan / debounce next-state logic; everything advances only on tick.
  always_comb begin
    state_next   = state;
    col_next     = COL;
    row_sel_next = row_sel;
    cnt_next     = cnt;
    accept       = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (srow == 4'b1111) begin
            col_next = {COL[2:0], COL[3]};
          end else begin
            casez (srow)
              4'b???0: row_sel_next = 2'd0;
              4'b??01: row_sel_next = 2'd1;
              4'b?011: row_sel_next = 2'd2;
              default: row_sel_next = 2'd3;
            endcase
            cnt_next   = CW'(1);
            state_next = DEB;
          end
        end
        DEB: begin
          if (!srow[row_sel]) begin
            if (cnt + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
              accept     = 1'b1;
              cnt_next   = '0;
              state_next = HELD;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end else begin
            col_next   = {COL[2:0], COL[3]};
            state_next = SCAN;
          end
        end
        HELD: begin
          if (srow[row_sel]) begin
            cnt_next   = CW'(1);
            state_next = REL;
          end
        end
        default: begin
          if (srow[row_sel]) begin
            if (cnt + CW'(1) == CW'(DEBOUNCE_SCANS)) begin
              cnt_next   = '0;
              col_next   = {COL[2:0], COL[3]};
              state_next = SCAN;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end else begin
            state_next = HELD;
          end
        end
      endcase
    end
  end

  // Entry datapath: digit accumulate with overflow reject, clear, backspace, enter.
  always_comb begin
    value_next   = value;
    entered_next = entered;
    enter_next   = 1'b0;
    ovf_next     = 1'b0;
    digit_sum    = NW'(value) * NW'(10) + NW'(code);
    if (accept) begin
      if (code <= 4'd9) begin
        if (digit_sum > NW'(8191)) ovf_next = 1'b1;
        else                       value_next = digit_sum[VW-1:0];
      end else begin
        case (code)
          4'hA: value_next = '0;
          4'hB: value_next = value / VW'(10);
          4'hE: begin
            entered_next = value;
            value_next   = '0;
            enter_next   = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta  <= 4'b1111;
      srow      <= 4'b1111;
      div       <= '0;
      state     <= SCAN;
      COL       <= 4'b1110;
      row_sel   <= '0;
      cnt       <= '0;
      value     <= '0;
      entered   <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      enter     <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      row_meta  <= ROW;
      srow      <= row_meta;
      div       <= div + SCAN_DIV_BITS'(1);
      state     <= state_next;
      COL       <= col_next;
      row_sel   <= row_sel_next;
      cnt       <= cnt_next;
      value     <= value_next;
      entered   <= entered_next;
      if (accept) key_code <= code;
      key_valid <= accept;
      enter     <= enter_next;
      ovf       <= ovf_next;
    end
  end
endmodule

// File: tb/tb_keypad_scan_entry.sv
// Scoreboard bench for keypad_scan_entry: a keypad model drives ROW from COL,
// expected key results are queued per press and checked on each key_valid.
module tb_keypad_scan_entry;
  localparam int unsigned DIV = 2;
  localparam int unsigned DEB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  ROW, COL;
  logic [12:0] value, entered;
  logic [3:0]  key_code;
  logic        key_valid, enter, ovf;

  keypad_scan_entry #(.SCAN_DIV_BITS(DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .ROW(ROW), .COL(COL), .value(value), .entered(entered),
    .key_code(key_code), .key_valid(key_valid), .enter(enter), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [12:0] value;
    logic [12:0] entered;
    logic        enter;
    logic        ovf;
    logic [3:0]  col;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0, kv_seen = 0;
  int   mval = 0, ment = 0;
  int   kmap[4][4];
  bit   pressed = 1'b0;
  int   pr = 0, pc = 0;

  // Physical keypad: a held key shorts its row low while its column is driven low.
  always_comb begin
    ROW = 4'b1111;
    if (pressed && !COL[pc]) ROW[pr] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input int r, input int c, output exp_t e);
    int k, nv;
    k = kmap[r][c];
    e.enter = 1'b0;
    e.ovf = 1'b0;
    if (k <= 9) begin
      nv = mval * 10 + k;
      if (nv > 8191) e.ovf = 1'b1;
      else mval = nv;
    end else if (k == 10) mval = 0;
    else if (k == 11) mval = mval / 10;
    else if (k == 14) begin
      ment = mval;
      mval = 0;
      e.enter = 1'b1;
    end
    e.code = 4'(k);
    e.value = 13'(mval);
    e.entered = 13'(ment);
    e.col = ~(4'b0001 << c);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (key_valid) begin
        kv_seen++;
        if (exp_q.size() == 0) check("spurious_key_valid", 32'(key_valid), 0);
        else begin
          e = exp_q.pop_front();
          check("key_code", 32'(key_code), 32'(e.code));
          check("value", 32'(value), 32'(e.value));
          check("entered", 32'(entered), 32'(e.entered));
          check("enter", 32'(enter), 32'(e.enter));
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("col_frozen", 32'(COL), 32'(e.col));
        end
      end else if (enter || ovf) begin
        check("stray_pulse", 32'({enter, ovf}), 0);
      end
    end
  end

  task automatic press(input int r, input int c, input int extra, input bit release_key);
    exp_t e;
    int   seen0;
    bit   got;
    model(r, c, e);
    exp_q.push_back(e);
    pr = r;
    pc = c;
    pressed = 1'b1;
    seen0 = kv_seen;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (kv_seen != seen0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL press_timeout: key r%0d c%0d got no key_valid", r, c);
      void'(exp_q.pop_back());
    end
    repeat (extra) @(posedge clk);
    if (release_key) begin
      pressed = 1'b0;
      repeat (30) @(posedge clk);
    end
  endtask

  initial begin
    int cycles;
    kmap = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

    // Reset state and idle column rotation.
    repeat (3) @(negedge clk);
    check("rst_col", 32'(COL), 32'(4'b1110));
    check("rst_value", 32'(value), 0);
    check("rst_key_valid", 32'(key_valid), 0);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      logic [3:0] ec;
      @(negedge clk);
      ec = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col", 32'(COL), 32'(ec));
    end

    // Clean key 5, then 1,2,3,E.
    press(1, 1, 8, 1'b1);
    press(1, 0, 0, 1'b1);  // value 54 -> cleared below
    press(0, 3, 0, 1'b1);
    press(0, 0, 3, 1'b1);
    press(0, 1, 5, 1'b1);
    press(0, 2, 0, 1'b1);
    press(3, 2, 2, 1'b1);

    // Bounce on key 5: one low sample then high; scanning resumes at col2.
    pr = 1;
    pc = 1;
    cycles = 0;
    while (COL != 4'b1110 && cycles < 100) begin @(posedge clk); #1; cycles++; end
    while (COL != 4'b1101 && cycles < 100) begin @(posedge clk); #1; cycles++; end
    check("bounce_sync", 32'(COL), 32'(4'b1101));
    pressed = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pressed = 1'b0;
    check("bounce_frozen", 32'(COL), 32'(4'b1101));
    repeat (4) @(posedge clk);
    #1;
    check("bounce_resume", 32'(COL), 32'(4'b1011));
    repeat (20) @(posedge clk);
    check("bounce_value", 32'(value), 32'(mval));

    // Overflow boundary, backspace, clear; 8191 accepted; backspace/enter at 0.
    press(2, 1, 0, 1'b1);
    press(0, 0, 0, 1'b1);
    press(2, 2, 0, 1'b1);
    press(0, 1, 0, 1'b1);
    press(1, 3, 0, 1'b1);
    press(0, 3, 0, 1'b1);
    press(2, 1, 0, 1'b1);
    press(0, 0, 0, 1'b1);
    press(2, 2, 0, 1'b1);
    press(0, 0, 0, 1'b1);
    press(3, 2, 0, 1'b1);
    press(1, 3, 0, 1'b1);
    press(3, 2, 0, 1'b1);

    // Random presses.
    for (int i = 0; i < 40; i++)
      press(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 1'b1);

    // Reset while HELD with value 42.
    press(0, 3, 0, 1'b1);
    press(1, 0, 0, 1'b1);
    press(0, 1, 0, 1'b1);
    press(2, 3, 6, 1'b0);
    check("pre_reset_value", 32'(value), 42);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_mid_col", 32'(COL), 32'(4'b1110));
    check("rst_mid_value", 32'(value), 0);
    check("rst_mid_entered", 32'(entered), 0);
    check("rst_mid_key_code", 32'(key_code), 0);
    check("rst_mid_pulses", 32'({key_valid, enter, ovf}), 0);
    pressed = 1'b0;
    mval = 0;
    ment = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    check("post_reset_value", 32'(value), 0);
    press(3, 0, 0, 1'b1);
    press(2, 2, 0, 1'b1);
    press(3, 2, 0, 1'b1);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
